si5340_i2c_target: RTL and testbench



---
 rtl/si5340_i2c_target.sv | 259 +++++++++++++++++++++++++
 tb/tb_si5340_i2c_target.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si5340_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : si5340_i2c_target
// Brief    : I2C target with an Si5340-style paged register file and a write
//            monitor. Define SI5340_I2C_SPIKE_FILTER_EN to add input filtering.
// Revision : 1.0
// ============================================================================
module si5340_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h74,
    parameter int         PAGE_NUM   = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oen_o,
    output logic        busy_o,
    output logic        wr_valid_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o
);
    localparam int AW = $clog2(PAGE_NUM * 256);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_REG       = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_MACK      = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    if (PAGE_NUM < 1 || PAGE_NUM > 256 || FILTER_LEN < 1) begin : g_param_check
        $error("si5340_i2c_target: illegal PAGE_NUM or FILTER_LEN");
    end

    // Bit 1 carries SCL, bit 0 carries SDA; idle bus level is high.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] line_f;
    logic [1:0] line_p_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {scl_i, sda_i};
            sync_q <= meta_q;
        end
    end

`ifdef SI5340_I2C_SPIKE_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    for (genvar g = 0; g < 2; g++) begin : g_filter
        logic          filt_q;
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                filt_q <= 1'b1;
                cnt_q  <= '0;
            end else if (sync_q[g] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[g];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign line_f[g] = filt_q;
    end
`else
    assign line_f = sync_q;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) line_p_q <= 2'b11;
        else          line_p_q <= line_f;
    end

    logic scl_w, sda_w, scl_p_w, sda_p_w;
    logic scl_rise, scl_fall, start_w, stop_w;
    assign scl_w    = line_f[1];
    assign sda_w    = line_f[0];
    assign scl_p_w  = line_p_q[1];
    assign sda_p_w  = line_p_q[0];
    assign scl_rise = scl_w & ~scl_p_w;
    assign scl_fall = ~scl_w & scl_p_w;
    assign start_w  = scl_w & scl_p_w & sda_p_w & ~sda_w;
    assign stop_w   = scl_w & scl_p_w & ~sda_p_w & sda_w;

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [7:0]  ptr_q;
    logic [7:0]  page_q;
    logic        rw_q;
    logic        oen_q;
    logic        busy_q;
    logic        wr_valid_q;
    logic [15:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic [7:0]    mem_q [PAGE_NUM * 256];
    logic [AW-1:0] mem_idx;
    logic          page_ok;
    logic [7:0]    rd_byte;
    logic          commit_w;
    logic          mem_we;

    assign shift_d  = {shift_q[6:0], sda_w};
    assign mem_idx  = AW'({page_q, ptr_q});
    assign page_ok  = (32'(page_q) < 32'(PAGE_NUM));
    assign commit_w = (state_q == S_WDATA) && scl_rise && (bit_cnt_q == 3'd7);
    assign mem_we   = commit_w && (ptr_q != 8'h01) && page_ok;

    // Offset 0x01 aliases the page register in every page.
    always_comb begin
        rd_byte = 8'h00;
        if (ptr_q == 8'h01) rd_byte = page_q;
        else if (page_ok)   rd_byte = mem_q[mem_idx];
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)    mem_q <= '{default: 8'h00};
        else if (mem_we) mem_q[mem_idx] <= shift_d;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            page_q     <= 8'h00;
            rw_q       <= 1'b0;
            oen_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_data_q  <= 8'h00;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_w) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= 3'd0;
                oen_q     <= 1'b1;
            end else if (stop_w) begin
                state_q <= S_IDLE;
                oen_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_d[7:1] == SLAVE_ADDR) begin
                                state_q <= S_ADDR_ACK;
                                busy_q  <= 1'b1;
                                rw_q    <= shift_d[0];
                            end else begin
                                state_q <= S_IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    // ACK states: first SCL fall drives ACK, second fall ends it.
                    S_ADDR_ACK: if (scl_fall) begin
                        if (oen_q) begin
                            oen_q <= 1'b0;
                        end else if (rw_q) begin
                            state_q   <= S_RDATA;
                            bit_cnt_q <= 3'd0;
                            oen_q     <= rd_byte[7];
                        end else begin
                            state_q   <= S_REG;
                            bit_cnt_q <= 3'd0;
                            oen_q     <= 1'b1;
                        end
                    end
                    S_REG: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= shift_d;
                            state_q <= S_REG_ACK;
                        end
                    end
                    S_REG_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (oen_q) begin
                            oen_q <= 1'b0;
                        end else begin
                            state_q   <= S_WDATA;
                            bit_cnt_q <= 3'd0;
                            oen_q     <= 1'b1;
                        end
                    end
                    S_WDATA: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (commit_w) begin
                            state_q    <= S_WDATA_ACK;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= {page_q, ptr_q};
                            wr_data_q  <= shift_d;
                            if (ptr_q == 8'h01) page_q <= shift_d;
                            ptr_q <= ptr_q + 8'd1;
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= S_MACK;
                        end else if (scl_fall) begin
                            oen_q <= rd_byte[~bit_cnt_q];
                        end
                    end
                    S_MACK: begin
                        if (scl_fall) begin
                            oen_q <= 1'b1;
                        end else if (scl_rise) begin
                            if (!sda_w) begin
                                ptr_q     <= ptr_q + 8'd1;
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_RDATA;
                            end else begin
                                state_q <= S_IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_o      = 1'b0;
    assign sda_oen_o  = oen_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_si5340_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_si5340_i2c_target
// Brief    : I2C master stimulus for si5340_i2c_target against a paged
//            register-file reference model.
// Revision : 1.0
// ============================================================================
module tb_si5340_i2c_target;
    localparam int         PAGES = 4;
    localparam int         Q     = 6;
    localparam logic [6:0] ADDR  = 7'h74;

    logic        clk_i   = 1'b0;
    logic        arstn_i = 1'b0;
    logic        scl_m   = 1'b1;
    logic        sda_m   = 1'b1;
    logic        sda_line;
    logic        sda_o, sda_oen_o, busy_o, wr_valid_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    always #5 clk_i = ~clk_i;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & (sda_oen_o | sda_o);

    si5340_i2c_target #(
        .SLAVE_ADDR (ADDR),
        .PAGE_NUM   (PAGES),
        .FILTER_LEN (3)
    ) dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .sda_oen_o  (sda_oen_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    logic [23:0] wr_log [1024];
    int          wr_cnt      = 0;
    int          oen_low_cnt = 0;

    always @(negedge clk_i) begin
        if (wr_valid_o && wr_cnt < 1024) begin
            wr_log[wr_cnt] = {wr_addr_o, wr_data_o};
            wr_cnt = wr_cnt + 1;
        end
        if (!sda_oen_o) oen_low_cnt = oen_low_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int log_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain page/offset array plus page register.
    logic [7:0] mdl_mem [PAGES][256];
    logic [7:0] mdl_page;

    task automatic mdl_clear();
        mdl_page = 8'h00;
        for (int p = 0; p < PAGES; p++)
            for (int o = 0; o < 256; o++) mdl_mem[p][o] = 8'h00;
    endtask

    task automatic mdl_write(input logic [7:0] off, input logic [7:0] d);
        if (off == 8'h01)              mdl_page = d;
        else if (int'(mdl_page) < PAGES) mdl_mem[int'(mdl_page)][off] = d;
    endtask

    function automatic logic [7:0] mdl_read(input logic [7:0] off);
        if (off == 8'h01)                return mdl_page;
        else if (int'(mdl_page) < PAGES) return mdl_mem[int'(mdl_page)][off];
        else                             return 8'h00;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk_i);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic byte_out(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic byte_in(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(~mack);
    endtask

    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    task automatic do_write(input logic [7:0] off, input int n);
        logic       ack;
        logic [7:0] o;
        o = off;
        start_c();
        byte_out({ADDR, 1'b0}, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
        byte_out(off, ack);          chk("wr_off_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            byte_out(wbuf[i], ack);
            chk("wr_data_ack", 32'(ack), 32'd1);
            chk("wr_mon_cnt", 32'(wr_cnt), 32'(log_rd + 1));
            if (wr_cnt > log_rd)
                chk("wr_mon_entry", 32'(wr_log[log_rd]), 32'({mdl_page, o, wbuf[i]}));
            log_rd = wr_cnt;
            mdl_write(o, wbuf[i]);
            o = o + 8'd1;
        end
        stop_c();
    endtask

    task automatic do_read(input logic [7:0] off, input int n);
        logic       ack;
        logic [7:0] o;
        o = off;
        start_c();
        byte_out({ADDR, 1'b0}, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
        byte_out(off, ack);          chk("rd_off_ack", 32'(ack), 32'd1);
        start_c();
        byte_out({ADDR, 1'b1}, ack); chk("rd_raddr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            byte_in(i < n - 1, rbuf[i]);
            chk("rd_data", 32'(rbuf[i]), 32'(mdl_read(o)));
            o = o + 8'd1;
        end
        stop_c();
    endtask

    task automatic set_page(input logic [7:0] pg);
        wbuf[0] = pg;
        do_write(8'h01, 1);
    endtask

    initial begin
        repeat (90000) @(posedge clk_i);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] off;
        int         n;
        int         cnt0;
        int         idx0;

        mdl_clear();
        repeat (5) @(negedge clk_i);
        chk("rst_oen", 32'(sda_oen_o), 32'd1);
        arstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_oen_run", 32'(sda_oen_o), 32'd1);

        // Two-byte write burst with busy tracking around STOP.
        idx0 = wr_cnt;
        start_c();
        byte_out({ADDR, 1'b0}, ack); chk("t1_addr_ack", 32'(ack), 32'd1);
        byte_out(8'h20, ack);        chk("t1_off_ack", 32'(ack), 32'd1);
        byte_out(8'hA5, ack);        chk("t1_d0_ack", 32'(ack), 32'd1);
        byte_out(8'h5A, ack);        chk("t1_d1_ack", 32'(ack), 32'd1);
        chk("t1_busy_before_stop", 32'(busy_o), 32'd1);
        stop_c();
        chk("t1_busy_after_stop", 32'(busy_o), 32'd0);
        chk("t1_mon_cnt", 32'(wr_cnt), 32'(idx0 + 2));
        chk("t1_mon0", 32'(wr_log[idx0]), 32'h0020A5);
        chk("t1_mon1", 32'(wr_log[idx0 + 1]), 32'h00215A);
        mdl_write(8'h20, 8'hA5);
        mdl_write(8'h21, 8'h5A);
        log_rd = wr_cnt;

        // Page select then read back through repeated START.
        set_page(8'h02);
        wbuf[0] = 8'h3C;
        do_write(8'h10, 1);
        chk("t2_mon_addr", 32'(wr_log[wr_cnt - 1][23:8]), 32'h0210);
        do_read(8'h10, 1);
        chk("t2_rd", 32'(rbuf[0]), 32'h3C);

        // Foreign address: NACK and no drive at all.
        cnt0 = oen_low_cnt;
        start_c();
        byte_out({7'h75, 1'b0}, ack); chk("t3_addr_nack", 32'(ack), 32'd0);
        byte_out(8'h10, ack);         chk("t3_byte_nack", 32'(ack), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd0);
        chk("t3_no_drive", 32'(oen_low_cnt), 32'(cnt0));
        stop_c();

        // Offset wrap in page 0.
        set_page(8'h00);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 3);
        do_read(8'hFE, 4);
        chk("t4_rd0", 32'(rbuf[0]), 32'h11);
        chk("t4_rd1", 32'(rbuf[1]), 32'h22);
        chk("t4_rd2", 32'(rbuf[2]), 32'h33);
        chk("t4_page_after_wrap", 32'(rbuf[3]), 32'h00);

        // Out-of-range page: acked and monitored, never stored.
        set_page(8'h05);
        wbuf[0] = 8'h77;
        do_write(8'h30, 1);
        chk("t5_mon", 32'(wr_log[wr_cnt - 1]), 32'h053077);
        do_read(8'h30, 1);
        chk("t5_rd_oor", 32'(rbuf[0]), 32'h00);
        do_read(8'h01, 1);
        chk("t5_rd_page", 32'(rbuf[0]), 32'h05);

        // Randomized bursts against the model, biased toward the wrap point.
        for (int it = 0; it < 8; it++) begin
            set_page(8'($urandom_range(0, 5)));
            n = $urandom_range(1, 4);
            off = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) off = 8'hFC + 8'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(off, n);
            do_read(off, n + 1);
        end

        // Reset while the target is driving a read bit low.
        set_page(8'h00);
        wbuf[0] = 8'h5E;
        do_write(8'h20, 1);
        start_c();
        byte_out({ADDR, 1'b0}, ack);
        byte_out(8'h20, ack);
        start_c();
        byte_out({ADDR, 1'b1}, ack); chk("t6_raddr_ack", 32'(ack), 32'd1);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        chk("t6_driving", 32'(sda_oen_o), 32'd0);
        @(negedge clk_i);
        arstn_i = 1'b0;
        #1;
        chk("t6_rst_release", 32'(sda_oen_o), 32'd1);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        repeat (4) @(negedge clk_i);
        arstn_i = 1'b1;
        sda_m = 1'b1;
        mdl_clear();
        repeat (4) @(negedge clk_i);
        log_rd = wr_cnt;
        do_read(8'h20, 1);
        chk("t6_rd_cleared", 32'(rbuf[0]), 32'h00);
        do_read(8'h01, 1);
        chk("t6_page_cleared", 32'(rbuf[0]), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
